// File: rtl/interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_arbiter
// Purpose  : Shares the CPU's single interrupt line among up to 8 bus
//            peripherals. Per-source raise levels are latched into a pending
//            register and filtered by a bus-programmable mask. One winner is
//            picked by fixed or round-robin priority and presented to the CPU
//            together with its ID. The CPU ack is routed back to that source
//            only, as a one-cycle one-hot pulse.
//
// Ports    : CLK            in    system clock
//            RESET          in    asynchronous, active-high reset
//            BUS_DATA       inout shared 8-bit data bus
//            BUS_ADDR       in    shared 8-bit address bus
//            BUS_WE         in    bus write enable
//            SRC_IRQ_RAISE  in    per-source raise level, held until acked
//            SRC_IRQ_ACK    out   one-hot, one-cycle ack to the winner
//            CPU_IRQ_RAISE  out   interrupt request to the CPU
//            CPU_IRQ_ID     out   index of the presented source
//            CPU_IRQ_ACK    in    CPU ack, honoured only in REQ
//
// Register window (BaseAddr + offset):
//            0 MASK    R/W   [N-1:0] enable bits, unused bits read 0
//            1 PENDING R/W1C pending bits, in-service bit cannot be cleared
//            2 STATUS  R     {busy, 4'b0, CPU_IRQ_ID}
//            3 MODE    R/W   bit0: 0 = fixed, 1 = round-robin priority
//
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_arbiter #(
  parameter logic [7:0] BaseAddr    = 8'hE0,
  parameter int         NUM_SOURCES = 4,
  parameter logic [7:0] InitialMask = 8'hFF,
  parameter logic       InitialMode = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  inout  wire  [7:0]             BUS_DATA,
  input  logic [7:0]             BUS_ADDR,
  input  logic                   BUS_WE,
  input  logic [NUM_SOURCES-1:0] SRC_IRQ_RAISE,
  output logic [NUM_SOURCES-1:0] SRC_IRQ_ACK,
  output logic                   CPU_IRQ_RAISE,
  output logic [2:0]             CPU_IRQ_ID,
  input  logic                   CPU_IRQ_ACK
);

  localparam logic [2:0]             c_last_idx  = 3'(NUM_SOURCES - 1);
  localparam logic [3:0]             c_num_src   = 4'(NUM_SOURCES);
  localparam logic [NUM_SOURCES-1:0] c_init_mask = InitialMask[NUM_SOURCES-1:0];

  localparam logic [1:0] c_reg_mask    = 2'd0;
  localparam logic [1:0] c_reg_pending = 2'd1;
  localparam logic [1:0] c_reg_status  = 2'd2;
  localparam logic [1:0] c_reg_mode    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                   state_q,   state_d;
  logic [2:0]               id_q,      id_d;
  logic [2:0]               rr_last_q, rr_last_d;
  logic [NUM_SOURCES-1:0]   pend_q,    pend_d;
  logic [NUM_SOURCES-1:0]   mask_q,    mask_d;
  logic                     mode_q,    mode_d;
  logic                     rd_en_q,   rd_en_d;
  logic [7:0]               rd_data_q, rd_data_d;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic [7:0] addr_off;
  logic       addr_hit;
  logic [1:0] reg_sel;
  logic       wr_mask;
  logic       wr_pending;
  logic       wr_mode;

  // Offset arithmetic keeps the decode correct for any base, aligned or not.
  assign addr_off   = BUS_ADDR - BaseAddr;
  assign addr_hit   = (addr_off[7:2] == 6'd0);
  assign reg_sel    = addr_off[1:0];
  assign wr_mask    = addr_hit && BUS_WE && (reg_sel == c_reg_mask);
  assign wr_pending = addr_hit && BUS_WE && (reg_sel == c_reg_pending);
  assign wr_mode    = addr_hit && BUS_WE && (reg_sel == c_reg_mode);

  // Upper data bits are only ever read back, never written, when N < 8.
  logic unused_bus_bits;
  assign unused_bus_bits = ^BUS_DATA;

  // --------------------------------------------------------------------------
  // In-service tracking
  // --------------------------------------------------------------------------
  logic                   in_service;
  logic [NUM_SOURCES-1:0] id_onehot;
  logic [NUM_SOURCES-1:0] blk;
  logic [NUM_SOURCES-1:0] clr;

  assign in_service = (state_q != ST_IDLE);

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      id_onehot[i] = (id_q == 3'(i));
    end
  end

  // The source in service may not re-arm itself until it has left ACK.
  assign blk = in_service ? id_onehot : '0;

  always_comb begin
    clr = '0;
    if (state_q == ST_ACK) begin
      clr = clr | id_onehot;
    end
    if (wr_pending) begin
      clr = clr | (BUS_DATA[NUM_SOURCES-1:0] & ~blk);
    end
  end

  assign pend_d = (pend_q | (SRC_IRQ_RAISE & ~blk)) & ~clr;
  assign mask_d = wr_mask ? BUS_DATA[NUM_SOURCES-1:0] : mask_q;
  assign mode_d = wr_mode ? BUS_DATA[0] : mode_q;

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
  logic [NUM_SOURCES-1:0] eligible;
  logic [7:0]             elig8;
  logic [2:0]             fixed_idx;
  logic [2:0]             rr_start;
  logic [2:0]             rr_idx;
  logic                   rr_found;
  logic [3:0]             rr_sum;

  assign eligible = pend_q & mask_q;
  assign elig8    = 8'(eligible);

  always_comb begin
    // Descending scan: the last hit is the lowest index.
    fixed_idx = 3'd0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (elig8[i]) begin
        fixed_idx = 3'(i);
      end
    end
  end

  always_comb begin
    rr_start = (rr_last_q >= c_last_idx) ? 3'd0 : (rr_last_q + 3'd1);
    rr_found = 1'b0;
    rr_idx   = 3'd0;
    rr_sum   = 4'd0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      rr_sum = {1'b0, rr_start} + 4'(k);
      if (rr_sum >= c_num_src) begin
        rr_sum = rr_sum - c_num_src;
      end
      if (!rr_found && elig8[rr_sum[2:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[2:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          id_d      = mode_q ? rr_idx : fixed_idx;
          // Tracked in both modes so a switch to round-robin continues
          // fairly from whoever was served last.
          rr_last_d = id_d;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (CPU_IRQ_ACK) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state so reset clears them at once)
  // --------------------------------------------------------------------------
  assign CPU_IRQ_RAISE = (state_q == ST_REQ);
  assign CPU_IRQ_ID    = (state_q == ST_REQ) ? id_q : 3'd0;
  assign SRC_IRQ_ACK   = (state_q == ST_ACK) ? id_onehot : '0;

  // --------------------------------------------------------------------------
  // Bus read path: the read is captured at the edge and driven next cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_en_d   = addr_hit && !BUS_WE;
    rd_data_d = 8'h00;
    case (reg_sel)
      c_reg_mask:    rd_data_d = 8'(mask_q);
      c_reg_pending: rd_data_d = 8'(pend_q);
      c_reg_status:  rd_data_d = {in_service, 4'b0000, CPU_IRQ_ID};
      c_reg_mode:    rd_data_d = {7'b0000000, mode_q};
      default:       rd_data_d = 8'h00;
    endcase
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      id_q      <= 3'd0;
      rr_last_q <= c_last_idx;
      pend_q    <= '0;
      mask_q    <= c_init_mask;
      mode_q    <= InitialMode;
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      rr_last_q <= rr_last_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_arbiter
// Purpose  : Directed self-checking bench for interrupt_arbiter (N = 4,
//            base 8'hE0, fixed priority at reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_arbiter;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  wire  [7:0]   BUS_DATA;
  logic [7:0]   BUS_ADDR;
  logic         BUS_WE;
  logic [N-1:0] SRC_IRQ_RAISE;
  logic [N-1:0] SRC_IRQ_ACK;
  logic         CPU_IRQ_RAISE;
  logic [2:0]   CPU_IRQ_ID;
  logic         CPU_IRQ_ACK;

  logic         drv_en;
  logic [7:0]   drv_data;

  int n_tests = 0;
  int n_fail  = 0;

  assign BUS_DATA = drv_en ? drv_data : 8'hzz;

  always #5 CLK = ~CLK;

  interrupt_arbiter #(
    .BaseAddr   (8'hE0),
    .NUM_SOURCES(N),
    .InitialMask(8'hFF),
    .InitialMode(1'b0)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BUS_DATA     (BUS_DATA),
    .BUS_ADDR     (BUS_ADDR),
    .BUS_WE       (BUS_WE),
    .SRC_IRQ_RAISE(SRC_IRQ_RAISE),
    .SRC_IRQ_ACK  (SRC_IRQ_ACK),
    .CPU_IRQ_RAISE(CPU_IRQ_RAISE),
    .CPU_IRQ_ID   (CPU_IRQ_ID),
    .CPU_IRQ_ACK  (CPU_IRQ_ACK)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Released bus: the simulator may resolve an undriven net to Z or to 0.
  function automatic logic bus_idle();
    return (BUS_DATA === 8'hzz) || (BUS_DATA === 8'h00);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a;
    BUS_WE   = 1'b1;
    drv_data = d;
    drv_en   = 1'b1;
    tick();
    BUS_WE   = 1'b0;
    drv_en   = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  // Extra cycle at the end lets the DUT release the bus before the next access.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    tick();
    d        = BUS_DATA;
    BUS_ADDR = 8'h00;
    tick();
  endtask

  task automatic serve(input logic [2:0] exp_id, input string tag);
    int         waited;
    logic [3:0] oh;
    waited = 0;
    oh     = 4'b0001 << exp_id;
    while (!CPU_IRQ_RAISE && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_req"}, 32'(CPU_IRQ_RAISE), 32'd1);
    if (CPU_IRQ_RAISE) begin
      check({tag, "_id"}, 32'(CPU_IRQ_ID), 32'(exp_id));
      CPU_IRQ_ACK = 1'b1;
      tick();
      CPU_IRQ_ACK = 1'b0;
      check({tag, "_src_ack"}, 32'(SRC_IRQ_ACK), 32'(oh));
      SRC_IRQ_RAISE = SRC_IRQ_RAISE & ~oh;
      tick();
      check({tag, "_ack_done"}, 32'({SRC_IRQ_ACK, CPU_IRQ_RAISE}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    int         highs;

    RESET         = 1'b1;
    BUS_ADDR      = 8'h00;
    BUS_WE        = 1'b0;
    SRC_IRQ_RAISE = '0;
    CPU_IRQ_ACK   = 1'b0;
    drv_en        = 1'b0;
    drv_data      = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_cpu_raise", 32'(CPU_IRQ_RAISE), 32'd0);
    check("rst_src_ack",   32'(SRC_IRQ_ACK),   32'd0);
    check("rst_cpu_id",    32'(CPU_IRQ_ID),    32'd0);
    check("rst_bus_idle",  32'(bus_idle()),    32'd1);
    RESET = 1'b0;
    bus_read(8'hE0, rd); check("rst_mask",   32'(rd), 32'h0F);
    bus_read(8'hE3, rd); check("rst_mode",   32'(rd), 32'h00);
    bus_read(8'hE2, rd); check("rst_status", 32'(rd), 32'h00);

    // 1: single source, latency and ack
    SRC_IRQ_RAISE = 4'b0100;
    tick(); check("t1_no_raise_edge0", 32'(CPU_IRQ_RAISE), 32'd0);
    tick(); check("t1_raise_edge1",    32'(CPU_IRQ_RAISE), 32'd1);
    check("t1_id", 32'(CPU_IRQ_ID), 32'd2);
    serve(3'd2, "t1");
    bus_read(8'hE1, rd); check("t1_pending_clear", 32'(rd), 32'h00);

    // 2: simultaneous raises, fixed then round-robin
    SRC_IRQ_RAISE = 4'b1010;
    serve(3'd1, "t2_fix_a");
    serve(3'd3, "t2_fix_b");
    bus_write(8'hE3, 8'h01);
    bus_read(8'hE3, rd); check("t2_mode_rb", 32'(rd), 32'h01);
    SRC_IRQ_RAISE = 4'b0010;
    serve(3'd1, "t2_rr_seed");
    SRC_IRQ_RAISE = 4'b1010;
    serve(3'd3, "t2_rr_a");
    serve(3'd1, "t2_rr_b");
    bus_write(8'hE3, 8'h00);

    // 3: masked source stays pending, dispatched once unmasked
    bus_write(8'hE0, 8'h0E);
    SRC_IRQ_RAISE = 4'b0001;
    highs = 0;
    repeat (4) begin
      tick();
      if (CPU_IRQ_RAISE) highs++;
    end
    check("t3_masked_no_req", 32'(highs), 32'd0);
    bus_read(8'hE1, rd); check("t3_pending", 32'(rd), 32'h01);
    bus_read(8'hE0, rd); check("t3_mask_rb", 32'(rd), 32'h0E);
    bus_write(8'hE0, 8'h0F);
    serve(3'd0, "t3_unmask");

    // 4: held raise through ACK gives one dispatch; W1C spares in-service bit
    SRC_IRQ_RAISE = 4'b0100;
    tick();
    tick();
    check("t4_req", 32'(CPU_IRQ_RAISE), 32'd1);
    check("t4_id",  32'(CPU_IRQ_ID),    32'd2);
    bus_write(8'hE1, 8'hFF);
    bus_read(8'hE1, rd); check("t4_inservice_kept", 32'(rd), 32'h04);
    check("t4_still_req", 32'(CPU_IRQ_RAISE), 32'd1);
    CPU_IRQ_ACK = 1'b1;
    tick();
    CPU_IRQ_ACK = 1'b0;
    check("t4_src_ack", 32'(SRC_IRQ_ACK), 32'h4);
    tick();
    SRC_IRQ_RAISE = '0;
    highs = 0;
    repeat (5) begin
      tick();
      if (CPU_IRQ_RAISE) highs++;
    end
    check("t4_single_dispatch", 32'(highs), 32'd0);
    bus_read(8'hE1, rd); check("t4_pending_empty", 32'(rd), 32'h00);

    // 5: reset during REQ aborts without ack, held raise is re-captured
    SRC_IRQ_RAISE = 4'b0010;
    tick();
    tick();
    check("t5_req", 32'(CPU_IRQ_RAISE), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("t5_rst_raise",   32'(CPU_IRQ_RAISE), 32'd0);
    check("t5_rst_id",      32'(CPU_IRQ_ID),    32'd0);
    check("t5_rst_src_ack", 32'(SRC_IRQ_ACK),   32'd0);
    highs = 0;
    repeat (2) begin
      tick();
      if (SRC_IRQ_ACK != '0 || CPU_IRQ_RAISE) highs++;
    end
    check("t5_quiet_in_reset", 32'(highs), 32'd0);
    RESET = 1'b0;
    tick(); check("t5_idle_after_release", 32'(CPU_IRQ_RAISE), 32'd0);
    tick(); check("t5_redispatch",         32'(CPU_IRQ_RAISE), 32'd1);
    check("t5_redispatch_id", 32'(CPU_IRQ_ID), 32'd1);
    serve(3'd1, "t5");

    // 6: STATUS read while presenting ID 3
    SRC_IRQ_RAISE = 4'b1000;
    tick();
    tick();
    check("t6_req", 32'(CPU_IRQ_RAISE), 32'd1);
    check("t6_bus_z_before", 32'(bus_idle()), 32'd1);
    BUS_ADDR = 8'hE2;
    tick();
    BUS_ADDR = 8'h00;
    check("t6_status", 32'(BUS_DATA), 32'h83);
    tick();
    check("t6_bus_z_after", 32'(bus_idle()), 32'd1);
    serve(3'd3, "t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
